// File: rtl/collider_pkg.sv
// Shared types for the table-driven level collider: rect_t, scan FSM state, bound accumulators.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package collider_pkg;

  // Coordinate width is fixed here because rect_t and acc_t are built from it.
  localparam int COORD_W      = 10;
  localparam int NUM_RECTS_DEF  = 16;
  localparam int NUM_LEVELS_DEF = 2;
  localparam int SCREEN_W_DEF   = 640;
  localparam int SCREEN_H_DEF   = 480;
  localparam int PLAYER_W_DEF   = 32;
  localparam int PLAYER_H_DEF   = 48;

  // Inclusive solid rectangle; x0<=x1, y0<=y1.
  typedef struct packed {
    logic               valid;
    logic               one_way;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
  } rect_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Running bounds while a scan walks the table; ymax_hit records that a rect set Y_Max.
  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
    logic               overlap;
    logic               ymax_hit;
  } acc_t;

  // Screen-limited default bounds: the full screen, no overlap, no floor.
  function automatic acc_t acc_init(input int screen_w, input int screen_h);
    acc_t a;
    a.x_min    = '0;
    a.x_max    = COORD_W'(screen_w - 1);
    a.y_min    = '0;
    a.y_max    = COORD_W'(screen_h - 1);
    a.overlap  = 1'b0;
    a.ymax_hit = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/collider_rect_eval.sv
// Applies one table rectangle to the running bounds for a player box at (px,py).
// Latency: purely combinational.
// Backpressure: none. Optional COLLIDER_ONE_WAY_EN makes one_way rects floor-only.
module collider_rect_eval
  import collider_pkg::*;
#(
  parameter int PLAYER_W = PLAYER_W_DEF,
  parameter int PLAYER_H = PLAYER_H_DEF
) (
  input  rect_t              rect,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  acc_t               acc_i,
  output acc_t               acc_o
);

  localparam int EW = COORD_W + 1;
  localparam logic [EW-1:0] PW = EW'(PLAYER_W);
  localparam logic [EW-1:0] PH = EW'(PLAYER_H);

`ifdef COLLIDER_ONE_WAY_EN
  localparam logic ONE_WAY_EN = 1'b1;
`else
  localparam logic ONE_WAY_EN = 1'b0;
`endif

  logic [EW-1:0] px_e, py_e, x0_e, y0_e, x1_e, y1_e;
  logic [EW-1:0] px_n, py_n, px_r, py_r;
  logic [EW-1:0] c_ymax, c_ymin, c_xmax, c_xmin;
  logic          hov, vov, solid;

  // Widen by one bit so player-edge sums never wrap, then fold this rect into the bounds.
  always_comb begin
    px_e   = {1'b0, px};
    py_e   = {1'b0, py};
    x0_e   = {1'b0, rect.x0};
    y0_e   = {1'b0, rect.y0};
    x1_e   = {1'b0, rect.x1};
    y1_e   = {1'b0, rect.y1};
    px_n   = px_e + PW;
    py_n   = py_e + PH;
    px_r   = px_n - EW'(1);
    py_r   = py_n - EW'(1);
    hov    = (x0_e <= px_r) && (x1_e >= px_e);
    vov    = (y0_e <= py_r) && (y1_e >= py_e);
    solid  = ~(rect.one_way & ONE_WAY_EN);
    c_ymax = y0_e - PH;
    c_ymin = y1_e + EW'(1);
    c_xmax = x0_e - PW;
    c_xmin = x1_e + EW'(1);
    acc_o  = acc_i;
    if (rect.valid) begin
      if (hov && vov) begin
        // Intersecting rects say "stuck inside" rather than constraining motion.
        acc_o.overlap = acc_i.overlap | solid;
      end else begin
        // Ties still mark the floor as rect-sourced for on_ground.
        if (hov && (y0_e >= py_n) && (c_ymax <= {1'b0, acc_i.y_max})) begin
          acc_o.y_max    = c_ymax[COORD_W-1:0];
          acc_o.ymax_hit = 1'b1;
        end
        if (solid) begin
          if (hov && (y1_e < py_e) && (c_ymin > {1'b0, acc_i.y_min})) begin
            acc_o.y_min = c_ymin[COORD_W-1:0];
          end
          if (vov && (x0_e >= px_n) && (c_xmax < {1'b0, acc_i.x_max})) begin
            acc_o.x_max = c_xmax[COORD_W-1:0];
          end
          if (vov && (x1_e < px_e) && (c_xmin > {1'b0, acc_i.x_min})) begin
            acc_o.x_min = c_xmin[COORD_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: rtl/collider_scanner.sv
// Per-level rectangle table scanned one entry per clock to produce player position bounds.
// Latency: done pulses NUM_RECTS+1 cycles after the accepted start edge; outputs hold until next done.
// Backpressure: start and tbl_we are dropped while busy. Optional feature: COLLIDER_ONE_WAY_EN.
module collider_scanner
  import collider_pkg::*;
#(
  parameter int NUM_RECTS  = NUM_RECTS_DEF,
  parameter int NUM_LEVELS = NUM_LEVELS_DEF,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int PLAYER_W   = PLAYER_W_DEF,
  parameter int PLAYER_H   = PLAYER_H_DEF,
  localparam int LVL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int NENT      = NUM_LEVELS * NUM_RECTS,
  localparam int AW        = (NENT > 1) ? $clog2(NENT) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [LVL_W-1:0]   level_sel,
  input  logic [COORD_W-1:0] player_X_Pos,
  input  logic [COORD_W-1:0] player_Y_Pos,
  input  logic               tbl_we,
  input  logic [AW-1:0]      tbl_addr,
  input  rect_t              tbl_rect,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] player_X_Min,
  output logic [COORD_W-1:0] player_X_Max,
  output logic [COORD_W-1:0] player_Y_Min,
  output logic [COORD_W-1:0] player_Y_Max,
  output logic               on_ground,
  output logic               overlap
);

  localparam int   IW      = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;
  localparam acc_t ACC_RST = acc_init(SCREEN_W, SCREEN_H);

  rect_t              tbl_q [NENT];
  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  acc_t               acc_q, acc_d, acc_eval;
  logic [COORD_W-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [COORD_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic               on_ground_q, on_ground_d, overlap_q, overlap_d;
  logic               done_q, done_d;
  logic               tbl_wr;
  logic [AW-1:0]      rd_addr;

  // Loader writes only land while idle so a scan sees a stable table.
  always_comb begin
    tbl_wr  = tbl_we && (state_q == IDLE) && (int'(tbl_addr) < NENT);
    rd_addr = AW'(int'(level_q) * NUM_RECTS + int'(idx_q));
  end

  // Table storage; reset invalidates every entry.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NENT; i++) tbl_q[i] <= '0;
    end else if (tbl_wr) begin
      tbl_q[tbl_addr] <= tbl_rect;
    end
  end

  collider_rect_eval #(
    .PLAYER_W (PLAYER_W),
    .PLAYER_H (PLAYER_H)
  ) u_eval (
    .rect  (tbl_q[rd_addr]),
    .px    (px_q),
    .py    (py_q),
    .acc_i (acc_q),
    .acc_o (acc_eval)
  );

  // Scan FSM: latch request, walk NUM_RECTS entries, then publish bounds with a done pulse.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    level_d     = level_q;
    px_d        = px_q;
    py_d        = py_q;
    acc_d       = acc_q;
    x_min_d     = x_min_q;
    x_max_d     = x_max_q;
    y_min_d     = y_min_q;
    y_max_d     = y_max_q;
    on_ground_d = on_ground_q;
    overlap_d   = overlap_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          level_d = level_sel;
          px_d    = player_X_Pos;
          py_d    = player_Y_Pos;
          acc_d   = ACC_RST;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d = acc_eval;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NUM_RECTS - 1)) state_d = DONE;
      end
      DONE: begin
        x_min_d     = acc_q.x_min;
        x_max_d     = acc_q.x_max;
        y_min_d     = acc_q.y_min;
        y_max_d     = acc_q.y_max;
        overlap_d   = acc_q.overlap;
        on_ground_d = acc_q.ymax_hit && (acc_q.y_max == py_q);
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any scan without a done pulse.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      level_q     <= '0;
      px_q        <= '0;
      py_q        <= '0;
      acc_q       <= ACC_RST;
      x_min_q     <= ACC_RST.x_min;
      x_max_q     <= ACC_RST.x_max;
      y_min_q     <= ACC_RST.y_min;
      y_max_q     <= ACC_RST.y_max;
      on_ground_q <= 1'b0;
      overlap_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      level_q     <= level_d;
      px_q        <= px_d;
      py_q        <= py_d;
      acc_q       <= acc_d;
      x_min_q     <= x_min_d;
      x_max_q     <= x_max_d;
      y_min_q     <= y_min_d;
      y_max_q     <= y_max_d;
      on_ground_q <= on_ground_d;
      overlap_q   <= overlap_d;
      done_q      <= done_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign player_X_Min = x_min_q;
  assign player_X_Max = x_max_q;
  assign player_Y_Min = y_min_q;
  assign player_Y_Max = y_max_q;
  assign on_ground    = on_ground_q;
  assign overlap      = overlap_q;

endmodule

// File: tb/tb_collider_scanner.sv
// Bench for collider_scanner: behavioural bounds model plus directed literal checks.
// Latency: model expects done NUM_RECTS+1 edges after an accepted start.
// Backpressure: model drops start/tbl_we while busy, as the design must.
module tb_collider_scanner;
  import collider_pkg::*;

  localparam int NR = 16, NL = 2, SW = 640, SH = 480, PW = 32, PH = 48;
  localparam int NE = NR * NL;
`ifdef COLLIDER_ONE_WAY_EN
  localparam bit OW = 1'b1;
`else
  localparam bit OW = 1'b0;
`endif

  typedef struct {
    int xmin, xmax, ymin, ymax, og, ov;
  } exp_t;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic               start;
  logic [0:0]         level_sel;
  logic [COORD_W-1:0] player_X_Pos, player_Y_Pos;
  logic               tbl_we;
  logic [4:0]         tbl_addr;
  rect_t              tbl_rect;
  logic               busy, done, on_ground, overlap;
  logic [COORD_W-1:0] player_X_Min, player_X_Max, player_Y_Min, player_Y_Max;

  collider_scanner #(
    .NUM_RECTS(NR), .NUM_LEVELS(NL), .SCREEN_W(SW), .SCREEN_H(SH),
    .PLAYER_W(PW), .PLAYER_H(PH)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .level_sel(level_sel),
    .player_X_Pos(player_X_Pos), .player_Y_Pos(player_Y_Pos),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_rect(tbl_rect),
    .busy(busy), .done(done),
    .player_X_Min(player_X_Min), .player_X_Max(player_X_Max),
    .player_Y_Min(player_Y_Min), .player_Y_Max(player_Y_Max),
    .on_ground(on_ground), .overlap(overlap)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  rect_t tbl_m [NE];
  exp_t  e_out, pending;
  bit    e_busy, e_done, chk_en, was_busy;
  int    m_cnt;

  function automatic exp_t defaults();
    exp_t e;
    e.xmin = 0; e.xmax = SW - 1; e.ymin = 0; e.ymax = SH - 1; e.og = 0; e.ov = 0;
    return e;
  endfunction

  // Bounds from the rules: min/max over every candidate each rect offers.
  function automatic exp_t model_scan(input int lvl, input int px, input int py);
    exp_t  e;
    rect_t r;
    int    fl;
    bit    hov, vov, solid;
    e  = defaults();
    fl = 1 << 30;
    for (int i = 0; i < NR; i++) begin
      r = tbl_m[lvl * NR + i];
      if (!r.valid) continue;
      solid = !(OW && r.one_way);
      hov = (int'(r.x0) <= px + PW - 1) && (int'(r.x1) >= px);
      vov = (int'(r.y0) <= py + PH - 1) && (int'(r.y1) >= py);
      if (hov && vov) begin
        if (solid) e.ov = 1;
        continue;
      end
      if (hov && int'(r.y0) >= py + PH && int'(r.y0) - PH < fl) fl = int'(r.y0) - PH;
      if (!solid) continue;
      if (hov && int'(r.y1) < py && int'(r.y1) + 1 > e.ymin) e.ymin = int'(r.y1) + 1;
      if (vov && int'(r.x0) >= px + PW && int'(r.x0) - PW < e.xmax) e.xmax = int'(r.x0) - PW;
      if (vov && int'(r.x1) < px && int'(r.x1) + 1 > e.xmin) e.xmin = int'(r.x1) + 1;
    end
    if (fl <= SH - 1) e.ymax = fl;
    e.og = (fl <= SH - 1 && e.ymax == py) ? 1 : 0;
    return e;
  endfunction

  // Cycle-level view: a scan is a countdown from the accepted start to the done edge.
  always @(posedge Clk) begin
    if (!Reset_n) begin
      m_cnt  = 0;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_out  = defaults();
      for (int i = 0; i < NE; i++) tbl_m[i] = '0;
      chk_en = 1'b1;
    end else begin
      was_busy = e_busy;
      e_done   = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          e_done = 1'b1;
          e_out  = pending;
        end
      end
      if (!was_busy && start) begin
        pending = model_scan(int'(level_sel), int'(player_X_Pos), int'(player_Y_Pos));
        m_cnt   = NR + 1;
      end
      if (!was_busy && tbl_we) tbl_m[tbl_addr] = tbl_rect;
      e_busy = (m_cnt > 0);
    end
  end

  // Every cycle after the first reset, all outputs must match the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("x_min", int'(player_X_Min), e_out.xmin);
      chk("x_max", int'(player_X_Max), e_out.xmax);
      chk("y_min", int'(player_Y_Min), e_out.ymin);
      chk("y_max", int'(player_Y_Max), e_out.ymax);
      chk("on_ground", int'(on_ground), e_out.og);
      chk("overlap", int'(overlap), e_out.ov);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic rect_t mk(input bit v, input bit ow, input int x0, input int y0,
                               input int x1, input int y1);
    rect_t r;
    r.valid = v; r.one_way = ow;
    r.x0 = COORD_W'(x0); r.y0 = COORD_W'(y0); r.x1 = COORD_W'(x1); r.y1 = COORD_W'(y1);
    return r;
  endfunction

  function automatic rect_t rand_rect();
    int x0, y0;
    x0 = $urandom_range(0, 600);
    y0 = $urandom_range(0, 460);
    return mk($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), x0, y0,
              x0 + $urandom_range(0, 150), y0 + $urandom_range(0, 100));
  endfunction

  task automatic wr(input int addr, input rect_t r);
    @(negedge Clk);
    tbl_we = 1'b1; tbl_addr = 5'(addr); tbl_rect = r;
    @(negedge Clk);
    tbl_we = 1'b0;
  endtask

  task automatic kick(input int lvl, input int px, input int py);
    @(negedge Clk);
    start = 1'b1; level_sel = 1'(lvl);
    player_X_Pos = COORD_W'(px); player_Y_Pos = COORD_W'(py);
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic scan(input int lvl, input int px, input int py);
    int n;
    kick(lvl, px, py);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("latency", n, 17);
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    repeat (cycles) begin
      @(negedge Clk);
      if (done) nd++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int nd;
    Reset_n = 1'b0; start = 1'b0; level_sel = '0; player_X_Pos = '0; player_Y_Pos = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_rect = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_xmax", int'(player_X_Max), 639);
    chk("rst_ymax", int'(player_Y_Max), 479);
    Reset_n = 1'b1;

    // Empty table
    scan(0, 100, 200);
    chk("empty_xmin", int'(player_X_Min), 0);
    chk("empty_xmax", int'(player_X_Max), 639);
    chk("empty_ymin", int'(player_Y_Min), 0);
    chk("empty_ymax", int'(player_Y_Max), 479);
    chk("empty_og", int'(on_ground), 0);
    chk("empty_ov", int'(overlap), 0);

    // Floors
    wr(0, mk(1, 0, 0, 415, 575, 479));
    scan(0, 100, 300);
    chk("floor_ymax", int'(player_Y_Max), 367);
    chk("floor_og0", int'(on_ground), 0);
    scan(0, 100, 367);
    chk("rest_ymax", int'(player_Y_Max), 367);
    chk("rest_og1", int'(on_ground), 1);
    wr(1, mk(1, 0, 0, 351, 255, 360));
    scan(0, 100, 250);
    chk("two_floor_ymax", int'(player_Y_Max), 303);

    // Wall and ceiling
    wr(2, mk(1, 0, 528, 300, 543, 400));
    scan(0, 400, 320);
    chk("wall_xmax", int'(player_X_Max), 496);
    scan(0, 560, 320);
    chk("wall_xmin", int'(player_X_Min), 544);
    wr(3, mk(1, 1, 0, 250, 255, 270));
    scan(0, 100, 300);
    chk("ceil_ymin", int'(player_Y_Min), OW ? 0 : 271);

    // Reset at scan cycle 5
    kick(0, 100, 300);
    repeat (4) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ymin", int'(player_Y_Min), 0);
    chk("midrst_ymax", int'(player_Y_Max), 479);
    count_done(25, nd);
    chk("midrst_no_done", nd, 0);
    scan(0, 100, 300);
    chk("cleared_ymax", int'(player_Y_Max), 479);
    chk("cleared_ymin", int'(player_Y_Min), 0);

    // Level selection
    wr(16, mk(1, 0, 0, 415, 575, 479));
    scan(0, 100, 300);
    chk("l0_ymax", int'(player_Y_Max), 479);
    scan(1, 100, 300);
    chk("l1_ymax", int'(player_Y_Max), 367);
    scan(1, 100, 400);
    chk("l1_ov", int'(overlap), 1);
    chk("l1_ov_ymax", int'(player_Y_Max), 479);

    // start and tbl_we while busy are dropped
    kick(1, 100, 300);
    repeat (3) @(negedge Clk);
    start = 1'b1; player_Y_Pos = COORD_W'(400);
    tbl_we = 1'b1; tbl_addr = 5'd16; tbl_rect = '0;
    @(negedge Clk);
    start = 1'b0; tbl_we = 1'b0;
    count_done(40, nd);
    chk("single_done", nd, 1);
    chk("busy_ymax", int'(player_Y_Max), 367);
    chk("busy_ov", int'(overlap), 0);
    scan(1, 100, 300);
    chk("tbl_kept_ymax", int'(player_Y_Max), 367);

    // Randomised tables and positions
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
        wr($urandom_range(0, NE - 1), rand_rect());
      end
      if (it % 8 == 7) begin
        // Place the player exactly on a fresh floor to hit on_ground.
        wr($urandom_range(0, NR - 1), mk(1, 0, 0, 300, 600, 320));
        scan(0, $urandom_range(0, 560), 252);
      end else begin
        scan($urandom_range(0, 1), $urandom_range(0, 607), $urandom_range(0, 431));
      end
    end

    repeat (2) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
